// File: rtl/combi_pkg.sv
// Shared fetch definitions: queue depth, entry layout and the default bubble word.
// COMBI_FETCH_PREFETCH_EN selects 2-deep prefetch; otherwise a single word is in flight.
package combi_pkg;

`ifdef COMBI_FETCH_PREFETCH_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    localparam int          FETCH_CNT_W          = $clog2(FETCH_DEPTH + 1);
    localparam logic [31:0] DEFAULT_BUBBLE_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetch entries with synchronous clear; an empty FIFO hands a
// simultaneous push straight to the output, which gives the fetch bypass path.
module fetch_fifo
    import combi_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  fetch_entry_t     din_i,
    input  logic             pop_i,
    output fetch_entry_t     dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass, wr_en, rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;

    // Push and pop on an empty FIFO pass the word through without storing it.
    assign pass   = empty_o & push_i & pop_i;
    assign wr_en  = push_i & ~pass & (~full_o | pop_i);
    assign rd_en  = pop_i & ~empty_o;
    assign dout_o = empty_o ? din_i : mem_q[rd_q];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (wr_en) wr_d = ptr_inc(wr_q);
            if (rd_en) rd_d = ptr_inc(rd_q);
            if (wr_en && !rd_en)
                cnt_d = cnt_q + CNT_W'(1);
            else if (rd_en && !wr_en)
                cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !clr_i)
            mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/combi_fetch.sv
// Fetch stage and F/D register of the combined ARM/RISC-V core.
// Prefetch depth follows COMBI_FETCH_PREFETCH_EN through combi_pkg::FETCH_DEPTH.
module combi_fetch
    import combi_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = DEFAULT_BUBBLE_INSTR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRValid,
    input  logic [31:0] ImemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        wasNotFlushedD
);
    localparam int CW = FETCH_CNT_W;
    localparam int IW = CW + 2;

    logic [31:0]   pcf_q, pcf_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   pcd_q, pcd_d;
    logic [31:0]   pcp4_q, pcp4_d;
    logic          vld_q, vld_d;

    fetch_entry_t  pcq_din, pcq_dout, rsp_din, rsp_dout;
    logic          pcq_full, pcq_empty, rsp_full, rsp_empty;
    logic [CW-1:0] pcq_cnt, rsp_cnt;
    logic [IW-1:0] inflight;
    logic          hs, rsp_accept, d_load, rsp_pop;
    logic          unused_ok;

    // Requests still owed by memory (including ones to be dropped) plus buffered words.
    assign inflight = IW'(pcq_cnt) + IW'(drop_q) + IW'(rsp_cnt);
    assign ImemReq  = reset_n & ~PCSrcE & (inflight < IW'(FETCH_DEPTH));
    assign ImemAddr = pcf_q;
    assign hs       = ImemReq & ImemGnt;

    assign rsp_accept = ImemRValid & ~PCSrcE & (drop_q == '0);
    assign d_load     = ~FlushD & ~PCSrcE & ~StallD;
    assign rsp_pop    = d_load & (~rsp_empty | rsp_accept);

    assign pcq_din = '{pc: pcf_q, instr: 32'h0};
    assign rsp_din = '{pc: pcq_dout.pc, instr: ImemRData};

    assign unused_ok = ^{pcq_full, pcq_empty, rsp_full, pcq_dout.instr};

    fetch_fifo #(
        .DEPTH (FETCH_DEPTH),
        .CNT_W (CW)
    ) u_pc_queue (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clr_i   (PCSrcE),
        .push_i  (hs),
        .din_i   (pcq_din),
        .pop_i   (rsp_accept),
        .dout_o  (pcq_dout),
        .full_o  (pcq_full),
        .empty_o (pcq_empty),
        .count_o (pcq_cnt)
    );

    fetch_fifo #(
        .DEPTH (FETCH_DEPTH),
        .CNT_W (CW)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clr_i   (PCSrcE),
        .push_i  (rsp_accept),
        .din_i   (rsp_din),
        .pop_i   (rsp_pop),
        .dout_o  (rsp_dout),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .count_o (rsp_cnt)
    );

    always_comb begin
        pcf_d  = pcf_q;
        drop_d = drop_q;
        if (PCSrcE) begin
            pcf_d  = {PCTargetE[31:2], 2'b00};
            // A response arriving in the redirect cycle is already discarded.
            drop_d = pcq_cnt + drop_q - CW'(ImemRValid);
        end else begin
            if (hs)
                pcf_d = pcf_q + 32'd4;
            if (ImemRValid && (drop_q != '0))
                drop_d = drop_q - CW'(1);
        end
    end

    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        vld_d   = vld_q;
        if (FlushD || PCSrcE) begin
            instr_d = BUBBLE_INSTR;
            vld_d   = 1'b0;
        end else if (StallD) begin
            vld_d = vld_q;
        end else if (rsp_pop) begin
            instr_d = rsp_dout.instr;
            pcd_d   = rsp_dout.pc;
            pcp4_d  = rsp_dout.pc + 32'd4;
            vld_d   = 1'b1;
        end else begin
            instr_d = BUBBLE_INSTR;
            vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcf_q   <= RESET_PC;
            drop_q  <= '0;
            instr_q <= BUBBLE_INSTR;
            pcd_q   <= 32'h0;
            pcp4_q  <= 32'h0;
            vld_q   <= 1'b0;
        end else begin
            pcf_q   <= pcf_d;
            drop_q  <= drop_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            vld_q   <= vld_d;
        end
    end

    assign InstrD         = instr_q;
    assign PCD            = pcd_q;
    assign PCPlus4D       = pcp4_q;
    assign wasNotFlushedD = vld_q;

endmodule
